inner_product_test: RTL and testbench
=====================================

INNER_PRODUCT_TEST -- requirements
Module: inner_product_test

Interface
REQ-001 SHALL have parameter data_width, default 3, bit width of each unsigned vector element (legal >= 1).
REQ-002 SHALL have parameter num_elems, default 3, number of elements per vector (legal >= 1).
REQ-003 SHALL derive localparams IN_W = num_elems*data_width and OUT_W = 2*data_width + 32 (32-bit fixed growth field).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 outp  output  OUT_W  registered inner-product result.
REQ-008 outp_inps  output  IN_W  registered stimulus vector that produced the current outp.

Function
REQ-009 SHALL contain an internal free-running IN_W-bit stimulus counter cnt, +1 per rising edge, wrapping from 2^IN_W-1 to 0.
REQ-010 Element i (i = 0..num_elems-1) of a vector V SHALL be V[(i+1)*data_width-1 : i*data_width], unsigned.
REQ-011 Vector A SHALL be cnt; vector B SHALL be A element-reversed, B[i] = A[num_elems-1-i].
REQ-012 Result SHALL be sum over i of A[i]*B[i], unsigned, each product 2*data_width bits, sum zero-extended to OUT_W; no overflow or truncation is possible.
REQ-013 Pipeline stage 1 SHALL register all num_elems products of the current cnt together with a copy of cnt.
REQ-014 Pipeline stage 2 SHALL register the sum of the stage-1 products into outp and the stage-1 cnt copy into outp_inps.
REQ-015 Latency SHALL be exactly 2 rising edges from a cnt value to its result on outp; outp and outp_inps SHALL always be mutually consistent (outp = f(outp_inps)).
REQ-016 After the k-th rising edge following reset release, cnt SHALL equal k mod 2^IN_W and outp_inps SHALL equal (k-2) mod 2^IN_W for k >= 2.
REQ-017 Wrap-around SHALL be seamless: outp_inps goes 2^IN_W-1 -> 0 with results f(all ones) then 0, no stall or bubble.
REQ-018 The pipeline SHALL have no handshake or enable; every stage advances every cycle.

Reset
REQ-019 rst_n low SHALL immediately, without a clock edge, clear cnt, all stage-1 registers, outp and outp_inps to 0.
REQ-020 While rst_n is low all state SHALL hold at 0 regardless of clk.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight results; after release the sequence restarts per REQ-016 from cnt = 0.
REQ-022 Reset state SHALL be self-consistent: outp = 0 = f(0) with outp_inps = 0.

Verification (data_width = 3, num_elems = 3; IN_W = 9, OUT_W = 38)
REQ-023 Hold rst_n low, toggle clk -> outp = 0, outp_inps = 0 throughout; assert rst_n low asynchronously between edges -> both read 0 before the next edge.
REQ-024 Release reset, apply edges 1..5 -> outp_inps = 0,0,0,1,2,3 at edges 0..5 with outp = 0,0,0,0,0,0 (values 1 and 2 have a zero middle and end element).
REQ-025 outp_inps = 8 (A = {0,1,0}) -> outp = 1; outp_inps = 83 (A0=3, A1=2, A2=1) -> outp = 3*1 + 2*2 + 1*3 = 10.
REQ-026 outp_inps = 511 (all elements 7) -> outp = 147; next edge outp_inps = 0 -> outp = 0 (wrap check).
REQ-027 Run 600 cycles with a reference model -> every cycle outp equals the sum of A[i]*A[2-i] over the three elements of outp_inps, and outp_inps increments by exactly 1 mod 512.
REQ-028 Assert rst_n low at cycle 100 for 3 cycles, then release -> outputs go to 0 immediately and REQ-024 sequence repeats from the release point.

Source files
------------

// File: rtl/inner_product_test.sv
// Two-stage pipelined inner product of a free-running counter vector with its
// element-reversed copy; outp_inps tracks the counter value behind each outp.
module inner_product_test #(
    parameter int data_width = 3,
    parameter int num_elems  = 3,
    localparam int IN_W  = num_elems * data_width,
    localparam int OUT_W = 2 * data_width + 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] outp,
    output logic [IN_W-1:0]  outp_inps
);

    localparam int PW = 2 * data_width;

    logic [IN_W-1:0]  r_cnt;
    logic [IN_W-1:0]  r_cnt_s1;
    logic [PW-1:0]    r_prod [num_elems];
    logic [PW-1:0]    w_prod [num_elems];
    logic [OUT_W-1:0] w_sum;

    // B[i] = A[num_elems-1-i], so each product pairs mirrored element slices
    always_comb begin
        for (int unsigned i = 0; i < num_elems; i++) begin
            w_prod[i] = PW'(r_cnt[i*data_width +: data_width]) *
                        PW'(r_cnt[(num_elems-1-i)*data_width +: data_width]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < num_elems; i++) begin
            w_sum = w_sum + OUT_W'(r_prod[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_cnt_s1  <= '0;
            for (int unsigned i = 0; i < num_elems; i++) begin
                r_prod[i] <= '0;
            end
            outp      <= '0;
            outp_inps <= '0;
        end else begin
            r_cnt     <= r_cnt + IN_W'(1);
            r_cnt_s1  <= r_cnt;
            for (int unsigned i = 0; i < num_elems; i++) begin
                r_prod[i] <= w_prod[i];
            end
            outp      <= w_sum;
            outp_inps <= r_cnt_s1;
        end
    end

endmodule

// File: tb/tb_inner_product_test.sv
// Bench for inner_product_test (data_width = 3, num_elems = 3): directed steps,
// randomized asynchronous reset pulses, and an arithmetic reference model.
module tb_inner_product_test;

    localparam int DW    = 3;
    localparam int NE    = 3;
    localparam int IN_W  = NE * DW;
    localparam int OUT_W = 2 * DW + 32;
    localparam int MODV  = 1 << IN_W;

    logic             clk;
    logic             rst_n;
    logic [OUT_W-1:0] outp;
    logic [IN_W-1:0]  outp_inps;

    int n_cmp;
    int n_err;
    int k;        // rising edges since reset release

    inner_product_test #(
        .data_width(DW),
        .num_elems (NE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .outp     (outp),
        .outp_inps(outp_inps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ref_f(input int unsigned v);
        int unsigned a0, a1, a2;
        a0 = v % 8;
        a1 = (v / 8) % 8;
        a2 = (v / 64) % 8;
        return OUT_W'(a0 * a2 + a1 * a1 + a2 * a0);
    endfunction

    function automatic int unsigned exp_inps();
        return (k >= 2) ? int'(unsigned'(k - 2) % MODV) : 0;
    endfunction

    task automatic check_val(input string tag, input logic [OUT_W-1:0] got,
                             input logic [OUT_W-1:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_model(input string tag);
        int unsigned e;
        e = exp_inps();
        check_val({tag, " inps"}, OUT_W'(outp_inps), OUT_W'(e));
        check_val({tag, " outp"}, outp, ref_f(e));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) k++;
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic run_to(input int unsigned target, input string tag);
        int guard;
        guard = 0;
        while (exp_inps() != target && guard < 1000) begin
            step(tag);
            guard++;
        end
        n_cmp++;
        assert (guard < 1000) else begin
            n_err++;
            $error("FAIL %s: observed timeout expected inps %0d", tag, target);
        end
    endtask

    // Async assert between edges, check immediately, hold, release at negedge
    task automatic async_reset(input int unsigned off, input int unsigned hold,
                               input string tag);
        @(negedge clk);
        #(off);
        rst_n = 1'b0;
        k = 0;
        #1;
        check_val({tag, " async inps"}, OUT_W'(outp_inps), '0);
        check_val({tag, " async outp"}, outp, '0);
        repeat (hold) step({tag, " held"});
        rst_n = 1'b1;
        k = 0;
        check_model({tag, " release"});
    endtask

    task automatic startup_seq(input string tag);
        for (int i = 0; i < 5; i++) begin
            step(tag);
            check_val({tag, " seq inps"}, OUT_W'(outp_inps),
                      OUT_W'((i + 1 >= 2) ? i - 1 : 0));
            check_val({tag, " seq outp"}, outp, '0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        k     = 0;
        rst_n = 1'b0;

        repeat (4) step("in reset");

        @(negedge clk);
        rst_n = 1'b1;
        check_model("edge0");
        startup_seq("first");

        run_to(8, "to8");
        check_val("inps8 outp", outp, OUT_W'(1));
        run_to(83, "to83");
        check_val("inps83 outp", outp, OUT_W'(10));
        run_to(511, "to511");
        check_val("inps511 outp", outp, OUT_W'(147));
        step("wrap");
        check_val("wrap inps", OUT_W'(outp_inps), '0);
        check_val("wrap outp", outp, '0);

        async_reset(2, 1, "reset a");
        while (k < 100) step("to cycle 100");
        check_val("cyc100 outp", outp, OUT_W'(20));
        async_reset(3, 3, "cyc100");
        startup_seq("after cyc100");

        repeat (600) step("run600");

        repeat (8) begin
            int unsigned len;
            len = $urandom_range(2, 30);
            repeat (len) step("rand run");
            async_reset($urandom_range(1, 3), $urandom_range(1, 4), "rand");
        end
        repeat (10) step("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
